mac_spike_scheduler: RTL and testbench

MAC_SPIKE_SCHEDULER -- requirements
Module: mac_spike_scheduler

---
 rtl/mac_spike_scheduler.sv | 127 ++++++++++++
 tb/tb_mac_spike_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_spike_scheduler.sv
// Spike scheduler for a MAC array: merges router and local spike ports into a FIFO
// and issues addresses with an IDLE cycle between each, then runs the timestep epilogue.
module mac_spike_scheduler #(
    parameter int                ADDR_W     = 12,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] IDLE_ADDR  = 12'hFFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in0_valid,
    input  logic [ADDR_W-1:0]             in0_addr,
    output logic                          in0_ready,
    input  logic                          in1_valid,
    input  logic [ADDR_W-1:0]             in1_addr,
    output logic                          in1_ready,
    input  logic                          timestep_end,
    output logic [ADDR_W-1:0]             source_address,
    output logic                          acc_en,
    output logic                          timestep_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ts_err,
    output logic [1:0]                    dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a transfer completes when inX_valid and inX_ready are both high at a
    // rising edge. Ready depends on valid so that at most one port is granted per cycle.
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               issue_q, issue_d;
    logic [ADDR_W-1:0]  src_q, src_d;
    logic               acc_p1_q, acc_p1_d, acc_en_q, acc_en_d;
    logic               done_q, done_d, ts_err_q, ts_err_d;
    logic               rr_last_q, rr_last_d;
    logic               flush_q, flush_d;

    logic               ready_ok, grant0, grant1, push;
    logic [ADDR_W-1:0]  push_addr, head;

    always_comb begin
        ready_ok  = (state_q == RUN) && (count_q != CNT_W'(FIFO_DEPTH));
        grant0    = ready_ok && in0_valid && (!in1_valid || rr_last_q);
        grant1    = ready_ok && in1_valid && (!in0_valid || !rr_last_q);
        push      = grant0 || grant1;
        push_addr = grant0 ? in0_addr : in1_addr;

        state_d = state_q;
        flush_d = flush_q;
        case (state_q)
            RUN:   if (timestep_end) state_d = DRAIN;
            DRAIN: if ((count_q == '0) && !issue_q) begin
                       state_d = FLUSH;
                       flush_d = 1'b0;
                   end
            FLUSH: if (flush_q) state_d = DONE;
                   else         flush_d = 1'b1;
            DONE:  state_d = RUN;
            default: state_d = RUN;
        endcase

        // An empty FIFO with a push this cycle forwards the incoming address directly,
        // so a spike accepted in cycle N is on source_address in cycle N+1.
        issue_d = !issue_q && ((state_d == RUN) || (state_d == DRAIN)) &&
                  ((count_q != '0) || push);
        head    = (count_q != '0) ? mem_q[rd_ptr_q] : push_addr;
        src_d   = issue_d ? head : IDLE_ADDR;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = push_addr;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(issue_d);
        count_d  = count_q + CNT_W'(push) - CNT_W'(issue_d);

        acc_p1_d  = issue_q;
        acc_en_d  = acc_p1_q;
        done_d    = (state_d == DONE);
        ts_err_d  = ts_err_q || (timestep_end && (state_q != RUN));
        rr_last_d = push ? grant1 : rr_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            issue_q   <= 1'b0;
            src_q     <= IDLE_ADDR;
            acc_p1_q  <= 1'b0;
            acc_en_q  <= 1'b0;
            done_q    <= 1'b0;
            ts_err_q  <= 1'b0;
            rr_last_q <= 1'b1;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            issue_q   <= issue_d;
            src_q     <= src_d;
            acc_p1_q  <= acc_p1_d;
            acc_en_q  <= acc_en_d;
            done_q    <= done_d;
            ts_err_q  <= ts_err_d;
            rr_last_q <= rr_last_d;
            flush_q   <= flush_d;
        end
    end

    assign in0_ready      = grant0;
    assign in1_ready      = grant1;
    assign source_address = src_q;
    assign acc_en         = acc_en_q;
    assign timestep_done  = done_q;
    assign fifo_count     = count_q;
    assign ts_err         = ts_err_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_mac_spike_scheduler.sv
// Bench for mac_spike_scheduler: scenario tasks checked against a queue-based
// timestep model, plus fixed-value checks on the documented example sequences.
module tb_mac_spike_scheduler;
    localparam logic [11:0] IDLE  = 12'hFFF;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in0_valid = 1'b0, in1_valid = 1'b0, timestep_end = 1'b0;
    logic [11:0] in0_addr = '0, in1_addr = '0;
    logic        in0_ready, in1_ready, acc_en, timestep_done, ts_err;
    logic [11:0] source_address;
    logic [3:0]  fifo_count;
    logic [1:0]  dbg_state;

    mac_spike_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_addr(in0_addr), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_ready(in1_ready),
        .timestep_end(timestep_end), .source_address(source_address),
        .acc_en(acc_en), .timestep_done(timestep_done), .fifo_count(fifo_count),
        .ts_err(ts_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // model: phase 0=RUN 1=DRAIN 2=FLUSH 3=DONE
    int          m_phase, m_flush;
    logic [11:0] m_q [$];
    bit          m_issue, m_acc1, m_acc2, m_err, m_rr_last;
    logic [11:0] m_src;
    bit          e_r0, e_r1;
    logic [20:0] exp_vec, got_vec;

    task automatic model_reset();
        m_phase = 0; m_flush = 0; m_q.delete();
        m_issue = 0; m_acc1 = 0; m_acc2 = 0; m_err = 0; m_rr_last = 1;
        m_src = IDLE;
    endtask

    task automatic set_in(bit v0, logic [11:0] a0, bit v1, logic [11:0] a1, bit te);
        in0_valid = v0; in0_addr = a0; in1_valid = v1; in1_addr = a1; timestep_end = te;
    endtask

    // Settles the current cycle's inputs and forms expected outputs for this cycle.
    task automatic model_eval();
        bit ok;
        #1;
        ok   = (m_phase == 0) && (m_q.size() < DEPTH);
        e_r0 = ok && in0_valid && (!in1_valid || m_rr_last);
        e_r1 = ok && in1_valid && (!in0_valid || !m_rr_last);
        exp_vec = {m_src, 4'(m_q.size()), e_r0, e_r1, m_acc2, (m_phase == 3), m_err};
        got_vec = {source_address, fifo_count, in0_ready, in1_ready, acc_en, timestep_done, ts_err};
    endtask

    // Applies the timestep rules for the coming edge, then waits for it.
    task automatic model_advance();
        int  size0, n;
        bit  nxt;
        size0 = m_q.size();
        if (e_r0) begin m_q.push_back(in0_addr); m_rr_last = 0; end
        else if (e_r1) begin m_q.push_back(in1_addr); m_rr_last = 1; end
        if (timestep_end && m_phase != 0) m_err = 1;
        n = m_phase;
        case (m_phase)
            0: if (timestep_end) n = 1;
            1: if (size0 == 0 && !m_issue) begin n = 2; m_flush = 2; end
            2: begin m_flush--; if (m_flush == 0) n = 3; end
            default: n = 0;
        endcase
        nxt    = !m_issue && (n <= 1) && (m_q.size() > 0);
        m_acc2 = m_acc1;
        m_acc1 = m_issue;
        m_src  = nxt ? m_q.pop_front() : IDLE;
        m_issue = nxt;
        m_phase = n;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1, 12'd5, 0, 12'd0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({source_address, fifo_count, in0_ready, in1_ready, acc_en, timestep_done, ts_err} !==
            {IDLE, 4'd0, 1'b1, 1'b0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_state: got src=%h cnt=%0d r0=%b r1=%b acc=%b done=%b err=%b",
                     source_address, fifo_count, in0_ready, in1_ready, acc_en, timestep_done, ts_err);
        end
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        for (int c = 0; c < 8; c++) begin
            set_in(c == 0, 12'd11, 0, 12'd0, 0);
            model_eval();
            n_vec++;
            if (got_vec !== exp_vec) begin
                n_err++; $display("FAIL single c%0d: got %h exp %h", c, got_vec, exp_vec);
            end
            n_vec++;
            if ((c == 1 && source_address !== 12'd11) || (c == 2 && source_address !== IDLE) ||
                (acc_en !== (c == 3))) begin
                n_err++; $display("FAIL single_fixed c%0d: src=%h acc=%b", c, source_address, acc_en);
            end
            model_advance();
        end
    endtask

    task automatic test_contention();
        logic [11:0] last_acc = IDLE;
        for (int c = 0; c < 34; c++) begin
            if (c < 12) set_in(1, 12'd4, 1, 12'd7, 0);
            else        set_in(0, 0, 0, 0, 0);
            model_eval();
            n_vec++;
            if (got_vec !== exp_vec) begin
                n_err++; $display("FAIL contention c%0d: got %h exp %h", c, got_vec, exp_vec);
            end
            if (c < 12) begin
                n_vec++;
                if ((in0_ready && last_acc == 12'd4) || (in1_ready && last_acc == 12'd7) ||
                    (!in0_ready && !in1_ready && m_q.size() < DEPTH)) begin
                    n_err++; $display("FAIL contention_order c%0d: r0=%b r1=%b last=%0d", c, in0_ready, in1_ready, last_acc);
                end
                if (in0_ready) last_acc = 12'd4;
                if (in1_ready) last_acc = 12'd7;
            end
            model_advance();
        end
    endtask

    task automatic test_full();
        int  guard = 0;
        bit  seen_full = 0;
        for (int c = 0; c < 60; c++) begin
            if (!seen_full || guard < 4)
                set_in(1, 12'($urandom_range(0, 4094)), 1, 12'($urandom_range(0, 4094)), 0);
            else
                set_in(0, 0, 0, 0, 0);
            model_eval();
            n_vec++;
            if (got_vec !== exp_vec) begin
                n_err++; $display("FAIL full c%0d: got %h exp %h", c, got_vec, exp_vec);
            end
            if (m_q.size() == DEPTH && !seen_full) begin
                seen_full = 1;
                n_vec++;
                if (fifo_count !== 4'd8 || in0_ready || in1_ready) begin
                    n_err++; $display("FAIL full_fixed: cnt=%0d r0=%b r1=%b exp 8 0 0", fifo_count, in0_ready, in1_ready);
                end
            end
            if (seen_full) guard++;
            model_advance();
        end
        n_vec++;
        if (!seen_full) begin n_err++; $display("FAIL full_reached: got 0 exp 1"); end
    endtask

    task automatic test_timestep();
        int acc_cnt = 0, done_cnt = 0, acc_n = 0;
        for (int c = 0; c < 24; c++) begin
            if (acc_n < 3) set_in(1, 12'($urandom_range(0, 4094)), 0, 0, acc_n == 2);
            else           set_in(0, 0, 0, 0, 0);
            model_eval();
            n_vec++;
            if (got_vec !== exp_vec) begin
                n_err++; $display("FAIL timestep c%0d: got %h exp %h", c, got_vec, exp_vec);
            end
            if (in0_valid && in0_ready) acc_n++;
            if (acc_en) acc_cnt++;
            if (timestep_done) done_cnt++;
            model_advance();
        end
        n_vec++;
        if (acc_cnt != 3 || done_cnt != 1) begin
            n_err++; $display("FAIL timestep_totals: acc=%0d done=%0d exp 3 1", acc_cnt, done_cnt);
        end
    endtask

    task automatic test_empty_err();
        for (int c = 0; c < 8; c++) begin
            set_in(0, 0, 0, 0, (c == 0) || (c == 1));
            model_eval();
            n_vec++;
            if (got_vec !== exp_vec) begin
                n_err++; $display("FAIL empty_ts c%0d: got %h exp %h", c, got_vec, exp_vec);
            end
            n_vec++;
            if (timestep_done !== (c == 4) || (c >= 2 && ts_err !== 1'b1)) begin
                n_err++; $display("FAIL empty_ts_fixed c%0d: done=%b err=%b", c, timestep_done, ts_err);
            end
            model_advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 320; c++) begin
            if (c < 300)
                set_in($urandom_range(0, 1), 12'($urandom_range(0, 4094)), $urandom_range(0, 1),
                       12'($urandom_range(0, 4094)), $urandom_range(0, 39) == 0);
            else
                set_in(0, 0, 0, 0, 0);
            model_eval();
            n_vec++;
            if (got_vec !== exp_vec) begin
                n_err++; $display("FAIL random c%0d: got %h exp %h", c, got_vec, exp_vec);
            end
            model_advance();
        end
    endtask

    task automatic test_reset_mid_drain();
        int guard = 0;
        while (m_q.size() < 5 && guard < 30) begin
            set_in(1, 12'($urandom_range(0, 4094)), 1, 12'($urandom_range(0, 4094)), 0);
            model_eval();
            n_vec++;
            if (got_vec !== exp_vec) begin
                n_err++; $display("FAIL rst_fill g%0d: got %h exp %h", guard, got_vec, exp_vec);
            end
            model_advance();
            guard++;
        end
        n_vec++;
        if (m_q.size() < 5) begin n_err++; $display("FAIL rst_fill_bound: got %0d exp 5", m_q.size()); end
        for (int c = 0; c < 2; c++) begin
            set_in(0, 0, 0, 0, c == 0);
            model_eval();
            n_vec++;
            if (got_vec !== exp_vec) begin
                n_err++; $display("FAIL rst_drain c%0d: got %h exp %h", c, got_vec, exp_vec);
            end
            model_advance();
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({source_address, fifo_count, acc_en, timestep_done} !== {IDLE, 4'd0, 2'b00}) begin
            n_err++; $display("FAIL rst_async: got src=%h cnt=%0d acc=%b done=%b", source_address, fifo_count, acc_en, timestep_done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 12; c++) begin
            set_in(0, 0, 0, 0, 0);
            model_eval();
            n_vec++;
            if (got_vec !== exp_vec || acc_en !== 1'b0 || timestep_done !== 1'b0) begin
                n_err++; $display("FAIL rst_after c%0d: got %h exp %h", c, got_vec, exp_vec);
            end
            model_advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_timestep();
        test_empty_err();
        test_random();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
